// File: rtl/ulpb_sleep_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ulpb_sleep_ctrl_pkg
//  Purpose  : Shared constants, state encoding and helpers for ulpb_sleep_ctrl
//  Revision : 1.0  initial release
// ============================================================================
package ulpb_sleep_ctrl_pkg;

    // Isolation levels shared with the wire controller
    localparam logic c_io_hold    = 1'b0;
    localparam logic c_io_release = 1'b1;

    localparam int c_def_step_cycles       = 1;
    localparam int c_def_pwr_settle_cycles = 4;
    localparam int c_def_cnt_w             = 4;

    typedef enum logic [2:0] {
        ST_ACTIVE = 3'd0,
        ST_S_ISO  = 3'd1,
        ST_S_RST  = 3'd2,
        ST_S_CLK  = 3'd3,
        ST_OFF    = 3'd4,
        ST_W_PWR  = 3'd5,
        ST_W_CLK  = 3'd6,
        ST_W_RST  = 3'd7
    } state_t;

    // Wake sources are only latched between isolation and power-off
    function automatic logic in_wake_window(input state_t s);
        return (s == ST_S_ISO) || (s == ST_S_RST) || (s == ST_S_CLK) || (s == ST_OFF);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ulpb_sleep_ctrl_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module   : ulpb_sleep_ctrl_sync_edge
//  Purpose  : 2-flop synchronizer with preset value; optional falling-edge
//             detect via a history flop, otherwise passes the synced level
//  Revision : 1.0  initial release
// ============================================================================
module ulpb_sleep_ctrl_sync_edge #(
    parameter logic RST_VAL = 1'b0,
    parameter bit   EDGE_EN = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_event
);

    logic r_s1;
    logic r_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= RST_VAL;
            r_s2 <= RST_VAL;
        end else begin
            r_s1 <= i_async;
            r_s2 <= r_s1;
        end
    end

    generate
        if (EDGE_EN) begin : g_edge
            logic r_s3;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_s3 <= RST_VAL;
                end else begin
                    r_s3 <= r_s2;
                end
            end
            assign o_event = r_s3 & ~r_s2;
        end else begin : g_level
            assign o_event = r_s2;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/ulpb_sleep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ulpb_sleep_ctrl
//  Purpose  : Power-sequencing FSM (isolate/reset/clock/power) for a bus node
//  Revision : 1.0  initial release
// ============================================================================
module ulpb_sleep_ctrl
    import ulpb_sleep_ctrl_pkg::*;
#(
    parameter int STEP_CYCLES       = c_def_step_cycles,
    parameter int PWR_SETTLE_CYCLES = c_def_pwr_settle_cycles,
    parameter int CNT_W             = c_def_cnt_w
) (
    input  logic       CLK,
    input  logic       RESETn,
    input  logic       SLEEP_REQ,
    input  logic       DIN,
    input  logic       EXTERNAL_INT,
    output logic       SLEEP,
    output logic       RELEASE_CLK,
    output logic       RELEASE_RST,
    output logic       RELEASE_ISO,
    output logic [1:0] WAKE_SRC
);

    localparam logic [CNT_W-1:0] c_step_last = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_pwr_last  = CNT_W'(PWR_SETTLE_CYCLES - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sleep;
    logic             r_rel_clk;
    logic             r_rel_rst;
    logic             r_rel_iso;
    logic [1:0]       r_wake;

    logic w_bus_ev;
    logic w_int_ev;
    logic w_wake_pend;
    logic w_step_done;
    logic w_pwr_done;

    ulpb_sleep_ctrl_sync_edge #(
        .RST_VAL (1'b1),
        .EDGE_EN (1'b1)
    ) u_sync_din (
        .clk     (CLK),
        .rst_n   (RESETn),
        .i_async (DIN),
        .o_event (w_bus_ev)
    );

    ulpb_sleep_ctrl_sync_edge #(
        .RST_VAL (1'b0),
        .EDGE_EN (1'b0)
    ) u_sync_int (
        .clk     (CLK),
        .rst_n   (RESETn),
        .i_async (EXTERNAL_INT),
        .o_event (w_int_ev)
    );

    assign w_wake_pend = (r_wake != 2'b00) | w_bus_ev | w_int_ev;
    assign w_step_done = (r_cnt == c_step_last);
    assign w_pwr_done  = (r_cnt == c_pwr_last);

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_state   <= ST_ACTIVE;
            r_cnt     <= '0;
            r_sleep   <= 1'b0;
            r_rel_clk <= 1'b1;
            r_rel_rst <= 1'b1;
            r_rel_iso <= c_io_release;
            r_wake    <= 2'b00;
        end else begin
            if (in_wake_window(r_state)) begin
                r_wake <= r_wake | {w_int_ev, w_bus_ev};
            end

            case (r_state)
                ST_ACTIVE: begin
                    if (SLEEP_REQ) begin
                        r_state   <= ST_S_ISO;
                        r_cnt     <= '0;
                        r_wake    <= 2'b00;
                        r_rel_iso <= c_io_hold;
                    end
                end
                ST_S_ISO: begin
                    if (w_step_done) begin
                        r_state   <= ST_S_RST;
                        r_cnt     <= '0;
                        r_rel_rst <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_S_RST: begin
                    if (w_step_done) begin
                        r_state   <= ST_S_CLK;
                        r_cnt     <= '0;
                        r_rel_clk <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_S_CLK: begin
                    if (w_step_done) begin
                        r_state <= ST_OFF;
                        r_cnt   <= '0;
                        r_sleep <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                // A wake latched during power-down is serviced here, so OFF lasts one cycle
                ST_OFF: begin
                    if (w_wake_pend) begin
                        r_state <= ST_W_PWR;
                        r_cnt   <= '0;
                        r_sleep <= 1'b0;
                    end
                end
                ST_W_PWR: begin
                    if (w_pwr_done) begin
                        r_state   <= ST_W_CLK;
                        r_cnt     <= '0;
                        r_rel_clk <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_W_CLK: begin
                    if (w_step_done) begin
                        r_state   <= ST_W_RST;
                        r_cnt     <= '0;
                        r_rel_rst <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_W_RST: begin
                    if (w_step_done) begin
                        r_state   <= ST_ACTIVE;
                        r_cnt     <= '0;
                        r_rel_iso <= c_io_release;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_ACTIVE;
                    r_cnt     <= '0;
                    r_sleep   <= 1'b0;
                    r_rel_clk <= 1'b1;
                    r_rel_rst <= 1'b1;
                    r_rel_iso <= c_io_release;
                end
            endcase
        end
    end

    assign SLEEP       = r_sleep;
    assign RELEASE_CLK = r_rel_clk;
    assign RELEASE_RST = r_rel_rst;
    assign RELEASE_ISO = r_rel_iso;
    assign WAKE_SRC    = r_wake;

endmodule
`default_nettype wire

// File: tb/tb_ulpb_sleep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ulpb_sleep_ctrl
//  Purpose  : Directed self-checking bench for ulpb_sleep_ctrl
//  Revision : 1.0  initial release
// ============================================================================
module tb_ulpb_sleep_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sleep_req = 1'b0, din = 1'b1, ext_int = 1'b0;
    logic       sleep, rel_clk, rel_rst, rel_iso;
    logic [1:0] wake_src;
    logic       req6 = 1'b0, din6 = 1'b1, ext6 = 1'b0;
    logic       sleep6, rel_clk6, rel_rst6, rel_iso6;
    logic [1:0] wake6;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ulpb_sleep_ctrl u_dut (
        .CLK          (clk),
        .RESETn       (rst_n),
        .SLEEP_REQ    (sleep_req),
        .DIN          (din),
        .EXTERNAL_INT (ext_int),
        .SLEEP        (sleep),
        .RELEASE_CLK  (rel_clk),
        .RELEASE_RST  (rel_rst),
        .RELEASE_ISO  (rel_iso),
        .WAKE_SRC     (wake_src)
    );

    ulpb_sleep_ctrl #(
        .STEP_CYCLES       (3),
        .PWR_SETTLE_CYCLES (7),
        .CNT_W             (4)
    ) u_dut6 (
        .CLK          (clk),
        .RESETn       (rst_n),
        .SLEEP_REQ    (req6),
        .DIN          (din6),
        .EXTERNAL_INT (ext6),
        .SLEEP        (sleep6),
        .RELEASE_CLK  (rel_clk6),
        .RELEASE_RST  (rel_rst6),
        .RELEASE_ISO  (rel_iso6),
        .WAKE_SRC     (wake6)
    );

    // Output vector order: {SLEEP, RELEASE_CLK, RELEASE_RST, RELEASE_ISO}
    function automatic logic [3:0] outs();
        return {sleep, rel_clk, rel_rst, rel_iso};
    endfunction

    function automatic logic [3:0] outs6();
        return {sleep6, rel_clk6, rel_rst6, rel_iso6};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(2);
        checks++;
        if (outs() !== 4'b0111) begin
            errors++;
            $display("FAIL reset_outs: got %b expected %b", outs(), 4'b0111);
        end
        checks++;
        if (wake_src !== 2'b00) begin
            errors++;
            $display("FAIL reset_wake: got %b expected %b", wake_src, 2'b00);
        end
        checks++;
        if ({outs6(), wake6} !== 6'b011100) begin
            errors++;
            $display("FAIL reset_dut6: got %b expected %b", {outs6(), wake6}, 6'b011100);
        end
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_sleep_seq();
        logic [3:0] exp [4] = '{4'b0110, 4'b0100, 4'b0000, 4'b1000};
        sleep_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            if (i == 0) sleep_req = 1'b0;
            checks++;
            if (outs() !== exp[i]) begin
                errors++;
                $display("FAIL sleep_seq_e%0d: got %b expected %b", i + 1, outs(), exp[i]);
            end
        end
        checks++;
        if (wake_src !== 2'b00) begin
            errors++;
            $display("FAIL sleep_seq_wake: got %b expected %b", wake_src, 2'b00);
        end
    endtask

    task automatic test_bus_wake();
        logic [3:0] exp [9] = '{4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000,
                                4'b0000, 4'b0100, 4'b0110, 4'b0111};
        din = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick(1);
            if (i == 1) din = 1'b1;
            checks++;
            if (outs() !== exp[i]) begin
                errors++;
                $display("FAIL bus_wake_e%0d: got %b expected %b", i + 1, outs(), exp[i]);
            end
        end
        checks++;
        if (wake_src !== 2'b01) begin
            errors++;
            $display("FAIL bus_wake_src: got %b expected %b", wake_src, 2'b01);
        end
    endtask

    task automatic test_int_wake();
        logic [3:0] exp [9] = '{4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000,
                                4'b0000, 4'b0100, 4'b0110, 4'b0111};
        sleep_req = 1'b1;
        tick(1);
        sleep_req = 1'b0;
        checks++;
        if (wake_src !== 2'b00) begin
            errors++;
            $display("FAIL int_wake_clear: got %b expected %b", wake_src, 2'b00);
        end
        tick(3);
        checks++;
        if (outs() !== 4'b1000) begin
            errors++;
            $display("FAIL int_wake_off: got %b expected %b", outs(), 4'b1000);
        end
        ext_int = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick(1);
            if (i == 2) ext_int = 1'b0;
            checks++;
            if (outs() !== exp[i]) begin
                errors++;
                $display("FAIL int_wake_e%0d: got %b expected %b", i + 1, outs(), exp[i]);
            end
        end
        checks++;
        if (wake_src !== 2'b10) begin
            errors++;
            $display("FAIL int_wake_src: got %b expected %b", wake_src, 2'b10);
        end
        // Bus traffic while ACTIVE must not disturb anything
        for (int i = 0; i < 6; i++) begin
            din = ~din;
            tick(1);
            checks++;
            if ({outs(), wake_src} !== 6'b011110) begin
                errors++;
                $display("FAIL active_din_%0d: got %b expected %b", i, {outs(), wake_src}, 6'b011110);
            end
        end
    endtask

    task automatic test_both_wake();
        logic [3:0] exp [11] = '{4'b0110, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0000,
                                 4'b0000, 4'b0000, 4'b0100, 4'b0110, 4'b0111};
        sleep_req = 1'b1;
        din       = 1'b0;
        ext_int   = 1'b1;
        for (int i = 0; i < 11; i++) begin
            tick(1);
            if (i == 0) sleep_req = 1'b0;
            if (i == 1) din = 1'b1;
            if (i == 4) ext_int = 1'b0;
            checks++;
            if (outs() !== exp[i]) begin
                errors++;
                $display("FAIL both_wake_e%0d: got %b expected %b", i + 1, outs(), exp[i]);
            end
            if (i == 2) begin
                checks++;
                if (wake_src !== 2'b11) begin
                    errors++;
                    $display("FAIL both_wake_src_srst: got %b expected %b", wake_src, 2'b11);
                end
            end
        end
        checks++;
        if (wake_src !== 2'b11) begin
            errors++;
            $display("FAIL both_wake_src: got %b expected %b", wake_src, 2'b11);
        end
        tick(4);
        sleep_req = 1'b1;
        tick(1);
        sleep_req = 1'b0;
        checks++;
        if ({outs(), wake_src} !== 6'b011000) begin
            errors++;
            $display("FAIL both_wake_reclear: got %b expected %b", {outs(), wake_src}, 6'b011000);
        end
        tick(5);
        checks++;
        if ({outs(), wake_src} !== 6'b100000) begin
            errors++;
            $display("FAIL off_no_wake: got %b expected %b", {outs(), wake_src}, 6'b100000);
        end
    endtask

    task automatic test_reset_pulse();
        ext_int = 1'b1;
        tick(3);
        checks++;
        if ({outs(), wake_src} !== 6'b000010) begin
            errors++;
            $display("FAIL pulse_pre_wpwr: got %b expected %b", {outs(), wake_src}, 6'b000010);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({outs(), wake_src} !== 6'b011100) begin
            errors++;
            $display("FAIL pulse_in_wpwr: got %b expected %b", {outs(), wake_src}, 6'b011100);
        end
        ext_int = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        sleep_req = 1'b1;
        tick(1);
        sleep_req = 1'b0;
        tick(3);
        checks++;
        if (outs() !== 4'b1000) begin
            errors++;
            $display("FAIL pulse_pre_off: got %b expected %b", outs(), 4'b1000);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({outs(), wake_src} !== 6'b011100) begin
            errors++;
            $display("FAIL pulse_in_off: got %b expected %b", {outs(), wake_src}, 6'b011100);
        end
        tick(1);
        rst_n = 1'b1;
        tick(1);
        for (int i = 0; i < 6; i++) begin
            din = ~din;
            tick(1);
            checks++;
            if ({outs(), wake_src} !== 6'b011100) begin
                errors++;
                $display("FAIL post_reset_din_%0d: got %b expected %b", i, {outs(), wake_src}, 6'b011100);
            end
        end
    endtask

    task automatic test_param_timing();
        logic [3:0] prev, cur;
        int t_iso_f = -1, t_rst_f = -1, t_clk_f = -1, t_slp_r = -1;
        int t_slp_f = -1, t_clk_r = -1, t_rst_r = -1, t_iso_r = -1;
        prev = outs6();
        req6 = 1'b1;
        for (int c = 1; c <= 32; c++) begin
            tick(1);
            if (c == 1)  req6 = 1'b0;
            if (c == 10) ext6 = 1'b1;
            if (c == 14) ext6 = 1'b0;
            cur = outs6();
            if (prev[0] && !cur[0]) t_iso_f = c;
            if (!prev[0] && cur[0]) t_iso_r = c;
            if (prev[1] && !cur[1]) t_rst_f = c;
            if (!prev[1] && cur[1]) t_rst_r = c;
            if (prev[2] && !cur[2]) t_clk_f = c;
            if (!prev[2] && cur[2]) t_clk_r = c;
            if (!prev[3] && cur[3]) t_slp_r = c;
            if (prev[3] && !cur[3]) t_slp_f = c;
            prev = cur;
        end
        checks++;
        if (t_iso_f !== 1) begin errors++; $display("FAIL p_iso_fall: got %0d expected %0d", t_iso_f, 1); end
        checks++;
        if (t_rst_f !== 4) begin errors++; $display("FAIL p_rst_fall: got %0d expected %0d", t_rst_f, 4); end
        checks++;
        if (t_clk_f !== 7) begin errors++; $display("FAIL p_clk_fall: got %0d expected %0d", t_clk_f, 7); end
        checks++;
        if (t_slp_r !== 10) begin errors++; $display("FAIL p_sleep_rise: got %0d expected %0d", t_slp_r, 10); end
        checks++;
        if (t_slp_f !== 13) begin errors++; $display("FAIL p_sleep_fall: got %0d expected %0d", t_slp_f, 13); end
        checks++;
        if (t_clk_r !== 20) begin errors++; $display("FAIL p_clk_rise: got %0d expected %0d", t_clk_r, 20); end
        checks++;
        if (t_rst_r !== 23) begin errors++; $display("FAIL p_rst_rise: got %0d expected %0d", t_rst_r, 23); end
        checks++;
        if (t_iso_r !== 26) begin errors++; $display("FAIL p_iso_rise: got %0d expected %0d", t_iso_r, 26); end
        checks++;
        if (wake6 !== 2'b10) begin errors++; $display("FAIL p_wake_src: got %b expected %b", wake6, 2'b10); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        test_reset();
        test_sleep_seq();
        test_bus_wake();
        test_int_wake();
        test_both_wake();
        test_reset_pulse();
        test_param_timing();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ulpb_sleep_ctrl.md
Name: ulpb_sleep_ctrl

Overview:
Power-sequencing FSM for one bus node; it drives RELEASE_ISO_FROM_SLEEP_CTRL into the wire controller. On a sleep request it steps through isolate, reset, clock-gate and power-off. Bus activity (falling edge on DIN) or an external interrupt wakes the node, and the steps run in reverse. It sits between the bus controller, which issues SLEEP_REQ, and the wire controller and power switches.

Parameters:
STEP_CYCLES, 1, dwell in cycles for each isolate/reset/clock step, in both directions (min 1)
PWR_SETTLE_CYCLES, 4, dwell in cycles after power switch turns on, before the clock is released (min 1)
CNT_W, 4, dwell counter width; both dwell parameters must be ≤ 2^CNT_W-1

Ports:
CLK  input  1  always-on clock; all state changes on rising edge
RESETn  input  1  asynchronous active-low reset
SLEEP_REQ  input  1  sleep request from bus controller, synchronous to CLK; sampled only in ACTIVE
DIN  input  1  raw bus data line, asynchronous, idle high
EXTERNAL_INT  input  1  asynchronous external interrupt, active high level
SLEEP  output  1  power gate control; 1 = node power off
RELEASE_CLK  output  1  1 = node clock running
RELEASE_RST  output  1  1 = node reset released
RELEASE_ISO  output  1  `IO_RELEASE (1) = node drives bus; `IO_HOLD (0) = isolated, wire controller forwards DIN/CLKIN
WAKE_SRC  output  2  bit0 = bus wake, bit1 = external-interrupt wake; sticky

Behaviour:
- Reset (async, any state):
  - State ACTIVE; SLEEP=0, RELEASE_CLK=1, RELEASE_RST=1, RELEASE_ISO=`IO_RELEASE, WAKE_SRC=0.
  - Dwell counter 0.
  - DIN synchronizer flops preset to 1; EXTERNAL_INT synchronizer flops cleared to 0.
- Synchronizers:
  - DIN: 2-flop synchronizer s1, s2, plus history flop s3. Bus event = s3 & ~s2.
  - EXTERNAL_INT: 2-flop synchronizer. Interrupt event = synchronized level high.
- Outputs are registered and change on the same edge as the state change (Moore, no combinational paths).
- States and outputs (SLEEP/CLK/RST/ISO):
  - ACTIVE: 0/1/1/REL
  - S_ISO: 0/1/1/HOLD
  - S_RST: 0/1/0/HOLD
  - S_CLK: 0/0/0/HOLD
  - OFF: 1/0/0/HOLD
  - W_PWR: 0/0/0/HOLD
  - W_CLK: 0/1/0/HOLD
  - W_RST: 0/1/1/HOLD
- Transitions:
  - ACTIVE -> S_ISO when SLEEP_REQ=1. This edge also clears WAKE_SRC.
  - S_ISO -> S_RST -> S_CLK -> OFF: each step after STEP_CYCLES cycles in the state.
  - OFF -> W_PWR on the first edge with a pending wake.
  - W_PWR -> W_CLK after PWR_SETTLE_CYCLES cycles.
  - W_CLK -> W_RST after STEP_CYCLES cycles.
  - W_RST -> ACTIVE after STEP_CYCLES cycles. RELEASE_ISO returns to `IO_RELEASE on this edge, last.
- Dwell counter: loads 0 on state entry and increments each cycle. Exit when counter == dwell-1.
- Wake events:
  - In ACTIVE: ignored, since bus traffic is normal there.
  - In S_ISO..OFF: set the corresponding WAKE_SRC bit (sticky).
  - A wake that arrives during power-down does not abort the sequence. It is serviced on reaching OFF, and OFF lasts exactly 1 cycle.
  - Both sources at once: both WAKE_SRC bits set.
- SLEEP_REQ outside ACTIVE is ignored. SLEEP_REQ held high in ACTIVE after a wake starts a new sleep sequence, as designed.
- Invariant: RELEASE_ISO is `IO_HOLD in every state except ACTIVE. SLEEP=1 only when RELEASE_CLK=0 and RELEASE_RST=0.

Decomposition:
- ulpb_def.v holds `IO_HOLD=1'b0 and `IO_RELEASE=1'b1 (shared with the wire controller). It also holds the 3-bit state encodings and default step/settle constants.
- One sub-module: ulpb_sync_edge. It contains the 2-flop synchronizer with reset preset value as a parameter, an optional history flop, and a falling-edge output. It is instantiated for DIN (preset 1, edge on) and EXTERNAL_INT (preset 0, level).

Test Plan:
1. Defaults, SLEEP_REQ=1 for one cycle at edge 0 -> RELEASE_ISO=0 at e1, RELEASE_RST=0 at e2, RELEASE_CLK=0 at e3, SLEEP=1 at e4, WAKE_SRC=00.
2. In OFF, DIN falls between e0 and e1 -> SLEEP=0 at e3, RELEASE_CLK=1 at e7, RELEASE_RST=1 at e8, RELEASE_ISO=1 at e9, WAKE_SRC=01.
3. In OFF, EXTERNAL_INT rises before e1 -> SLEEP=0 at e3, WAKE_SRC=10. DIN toggling in ACTIVE -> no state change, WAKE_SRC unchanged.
4. EXTERNAL_INT and DIN fall both assert during S_RST -> sequence continues to OFF, OFF lasts 1 cycle, then W_PWR; WAKE_SRC=11. Next SLEEP_REQ clears it to 00.
5. RESETn pulsed low in W_PWR and in OFF -> outputs immediately 0/1/1/1 with WAKE_SRC=00; after release, DIN low-to-high activity in ACTIVE causes no transition.
6. Parameters STEP_CYCLES=3, PWR_SETTLE_CYCLES=7 -> each step state lasts exactly 3 cycles and W_PWR exactly 7 cycles; check with a cycle counter on every output edge.
